mic1_register_file: RTL and testbench

Register file of the MIC-1 microarchitecture datapath. It holds the ten architectural registers MAR, MDR, PC, MBR, SP, LV, CPP, TOS, OPC and H. It drives the B bus and the A bus (H) toward the ALU and loads registers from the C bus. It also generates the memory interface (address, write data, write enable) to the companion synchronous `ram` and captures its read/fetch data into MDR/MBR.

---
 rtl/mic1_register_file_if.sv | 29 ++
 rtl/mic1_register_file.sv | 75 +++++++
 tb/tb_mic1_register_file.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mic1_register_file_if.sv
// Datapath and memory-port bundle between the MIC-1 register file and its
// control/ALU/ram side.
interface mic1_register_file_if #(
  parameter int NBITS = 32,
  parameter int B     = 4,
  parameter int C     = 9,
  parameter int MEM   = 3
);
  logic [NBITS-1:0] c_bus;
  logic [C-1:0]     write_c;
  logic [B-1:0]     enable_b;
  logic [NBITS-1:0] b_bus;
  logic [NBITS-1:0] a_bus;
  logic [MEM-1:0]   mem_control;
  logic [NBITS-1:0] mem_in;
  logic [NBITS-1:0] mem_addr;
  logic [NBITS-1:0] mem_out;
  logic             we;

  modport master (
    output c_bus, write_c, enable_b, mem_control, mem_in,
    input  b_bus, a_bus, mem_addr, mem_out, we
  );

  modport slave (
    input  c_bus, write_c, enable_b, mem_control, mem_in,
    output b_bus, a_bus, mem_addr, mem_out, we
  );
endinterface

// File: rtl/mic1_register_file.sv
// MIC-1 register file: ten architectural registers, A/B bus drive, C-bus
// loads and the memory address/data/capture path to a registered-read ram.
module mic1_register_file #(
  parameter int NBITS = 32,
  parameter int B     = 4,
  parameter int C     = 9,
  parameter int MEM   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  mic1_register_file_if.slave   rf
);
  // Register indices match the write_c bit positions.
  localparam int R_MAR = 0;
  localparam int R_MDR = 1;
  localparam int R_PC  = 2;
  localparam int R_SP  = 3;
  localparam int R_LV  = 4;
  localparam int R_CPP = 5;
  localparam int R_TOS = 6;
  localparam int R_OPC = 7;
  localparam int R_H   = 8;

  localparam int M_WRITE = 2;
  localparam int M_READ  = 1;
  localparam int M_FETCH = 0;

  logic [C-1:0][NBITS-1:0] regs;
  logic [7:0]              mbr;
  logic                    rd_pend;
  logic                    fe_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs    <= '0;
      mbr     <= '0;
      rd_pend <= 1'b0;
      fe_pend <= 1'b0;
    end else begin
      for (int i = 0; i < C; i++)
        if (rf.write_c[i]) regs[i] <= rf.c_bus;
      // C-bus write to MDR takes priority over the pending read load.
      if (rd_pend && !rf.write_c[R_MDR]) regs[R_MDR] <= rf.mem_in;
      if (fe_pend) mbr <= rf.mem_in[7:0];
      rd_pend <= rf.mem_control[M_READ];
      // READ owns the address port, so a concurrent FETCH is dropped.
      fe_pend <= rf.mem_control[M_FETCH] & ~rf.mem_control[M_READ];
    end
  end

  always_comb begin
    rf.b_bus = '0;
    case (rf.enable_b)
      B'(0): rf.b_bus = regs[R_OPC];
      B'(1): rf.b_bus = regs[R_TOS];
      B'(2): rf.b_bus = regs[R_CPP];
      B'(3): rf.b_bus = regs[R_LV];
      B'(4): rf.b_bus = regs[R_SP];
      B'(5): rf.b_bus = {{(NBITS-8){mbr[7]}}, mbr};
      B'(6): rf.b_bus = regs[R_PC];
      B'(7): rf.b_bus = regs[R_MDR];
      B'(8): rf.b_bus = {{(NBITS-8){1'b0}}, mbr};
      default: rf.b_bus = '0;
    endcase
  end

  logic fetch_only;
  assign fetch_only  = rf.mem_control[M_FETCH] & ~rf.mem_control[M_READ]
                     & ~rf.mem_control[M_WRITE];

  assign rf.a_bus    = regs[R_H];
  assign rf.mem_addr = fetch_only ? regs[R_PC] : regs[R_MAR];
  assign rf.mem_out  = regs[R_MDR];
  assign rf.we       = rf.mem_control[M_WRITE];
endmodule

// File: tb/tb_mic1_register_file.sv
// Directed bench for mic1_register_file with a small registered-read ram
// model hanging off the memory port.
module tb_mic1_register_file;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mic1_register_file_if bus ();

  mic1_register_file dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus.slave)
  );

  logic [31:0] mem [0:15];
  logic [31:0] q;

  always @(posedge clk) begin
    if (bus.we) mem[bus.mem_addr[3:0]] <= bus.mem_out;
    q <= mem[bus.mem_addr[3:0]];
  end
  assign bus.mem_in = q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cwr(input logic [8:0] m, input logic [31:0] v);
    bus.write_c = m;
    bus.c_bus   = v;
    tick();
    bus.write_c = '0;
  endtask

  task automatic chk_b(input string tag, input logic [3:0] sel, input logic [31:0] exp);
    bus.enable_b = sel;
    #1;
    chk(tag, bus.b_bus, exp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'hDEAD0000;
    reset           = 1'b1;
    bus.write_c     = 9'h1FF;
    bus.c_bus       = 32'hFFFFFFFF;
    bus.enable_b    = '0;
    bus.mem_control = '0;

    // Reset holds everything at zero even with every write enabled.
    for (int s = 0; s < 16; s++) begin
      bus.enable_b = s[3:0];
      @(negedge clk);
      chk($sformatf("rst_b%0d", s), bus.b_bus, 32'h0);
    end
    chk("rst_a", bus.a_bus, 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_mout", bus.mem_out, 32'h0);
    bus.mem_control = 3'b100;
    #1;
    chk("rst_we", {31'h0, bus.we}, 32'h1);
    bus.mem_control = '0;
    bus.write_c = '0;
    bus.c_bus   = '0;
    tick();
    reset = 1'b0;

    // C-bus writes, A/B bus.
    cwr(9'h100, 32'hF0F0F0F0);
    chk("h_a", bus.a_bus, 32'hF0F0F0F0);
    chk_b("opc_b0", 4'd0, 32'h0);
    cwr(9'h080, 32'hF0F0F0F0);
    chk_b("opc_b1", 4'd0, 32'hF0F0F0F0);

    // Memory write then read back into MDR.
    cwr(9'h001, 32'd3);
    cwr(9'h002, 32'h12345678);
    bus.mem_control = 3'b100;
    #1;
    chk("wr_we", {31'h0, bus.we}, 32'h1);
    chk("wr_addr", bus.mem_addr, 32'd3);
    chk("wr_data", bus.mem_out, 32'h12345678);
    tick();
    bus.mem_control = '0;
    cwr(9'h002, 32'h0);
    bus.mem_control = 3'b010;
    tick();
    bus.mem_control = '0;
    chk_b("rd_edge1", 4'd7, 32'h0);
    tick();
    chk_b("rd_edge2", 4'd7, 32'h12345678);

    // Fetch from PC while MAR points elsewhere.
    cwr(9'h001, 32'd7);
    cwr(9'h004, 32'd3);
    bus.mem_control = 3'b001;
    #1;
    chk("fe_addr", bus.mem_addr, 32'd3);
    tick();
    bus.mem_control = '0;
    tick();
    chk_b("fe_mbru", 4'd8, 32'h00000078);

    // Sign vs zero extension of MBR.
    cwr(9'h001, 32'd4);
    cwr(9'h002, 32'h00000085);
    bus.mem_control = 3'b100;
    tick();
    bus.mem_control = '0;
    cwr(9'h004, 32'd4);
    bus.mem_control = 3'b001;
    tick();
    bus.mem_control = '0;
    tick();
    chk_b("mbr_sx", 4'd5, 32'hFFFFFF85);
    chk_b("mbr_zx", 4'd8, 32'h00000085);
    chk_b("bsel12", 4'd12, 32'h0);

    // READ together with FETCH: only MDR loads, from MAR.
    cwr(9'h001, 32'd3);
    cwr(9'h002, 32'h0);
    bus.mem_control = 3'b011;
    #1;
    chk("rf_addr", bus.mem_addr, 32'd3);
    tick();
    bus.mem_control = '0;
    tick();
    chk_b("rf_mdr", 4'd7, 32'h12345678);
    chk_b("rf_mbr", 4'd8, 32'h00000085);

    // MAR rewritten in the request cycle: request uses the old MAR.
    cwr(9'h002, 32'h0);
    bus.mem_control = 3'b010;
    bus.c_bus   = 32'd5;
    bus.write_c = 9'h001;
    tick();
    bus.write_c = '0;
    bus.mem_control = '0;
    tick();
    chk_b("old_mar", 4'd7, 32'h12345678);

    // C-bus MDR write beats the pending read load.
    cwr(9'h001, 32'd3);
    bus.mem_control = 3'b010;
    tick();
    bus.mem_control = '0;
    cwr(9'h002, 32'hCAFEBABE);
    chk_b("conflict", 4'd7, 32'hCAFEBABE);

    // Back-to-back reads deliver in order.
    bus.mem_control = 3'b010;
    bus.c_bus   = 32'd4;
    bus.write_c = 9'h001;
    tick();
    bus.write_c = '0;
    tick();
    chk_b("b2b_1", 4'd7, 32'h12345678);
    bus.mem_control = '0;
    tick();
    chk_b("b2b_2", 4'd7, 32'h00000085);

    // Reset in the cycle after a READ suppresses the load.
    cwr(9'h001, 32'd3);
    bus.mem_control = 3'b010;
    tick();
    bus.mem_control = '0;
    reset = 1'b1;
    #1;
    chk_b("rst_mid0", 4'd7, 32'h0);
    chk("rst_mid_addr", bus.mem_addr, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk_b("rst_mid1", 4'd7, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
